// File: rtl/lcd_bus_ctrl_pkg.sv
// Shared definitions for the HD44780 LCD bus controller: FSM encodings,
// controller command bytes and the buffered write entry format.
package lcd_bus_ctrl_pkg;

    localparam logic [2:0] ST_PWRUP = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_IDLE  = 3'd5;

    localparam logic [7:0] FUNC_SET_8BIT_2L = 8'h38;
    localparam logic [7:0] DISP_ON          = 8'h0C;
    localparam logic [7:0] CLEAR            = 8'h01;
    localparam logic [7:0] ENTRY_INC        = 8'h06;
    localparam logic [7:0] HOME             = 8'h02;

    localparam logic [1:0] INIT_LAST = 2'd3;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET_8BIT_2L;
            2'd1:    return DISP_ON;
            2'd2:    return CLEAR;
            default: return ENTRY_INC;
        endcase
    endfunction

    // Clear and home need the long post-strobe delay on the controller side.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CLEAR) || (data == HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_ctrl_wr_fifo.sv
// Write buffer for LCD bytes: DEPTH entries of {rs,data}, power-of-2 depth,
// a push into a full buffer is only taken when a pop happens the same cycle.
module lcd_wr_fifo
    import lcd_bus_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  lcd_entry_t               din,
    output lcd_entry_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    lcd_entry_t    mem_q [DEPTH];
    lcd_entry_t    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full_q || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_CNT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/lcd_bus_ctrl.sv
// HD44780 8-bit bus driver: self-running power-up init, then drains CPU-written
// bytes from the write buffer with open-loop EN/command timing.
module lcd_bus_ctrl
    import lcd_bus_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int T_PWRUP    = 750000,
    parameter int T_EN       = 25,
    parameter int T_CMD      = 2500,
    parameter int T_CLEAR    = 82000
)
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       init_done,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int FW     = $clog2(FIFO_DEPTH) + 1;
    localparam int T_MAX1 = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
    localparam int T_MAX2 = (T_CMD > T_EN) ? T_CMD : T_EN;
    localparam int T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int CNT_W  = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);
    localparam logic [FW-1:0]    FULL_CNT   = FW'(FIFO_DEPTH);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_last;
    logic [1:0]       init_idx_q, init_idx_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_en_q, lcd_en_d;
    logic             init_done_q, init_done_d;
    logic             overflow_q, overflow_d;

    logic             fifo_pop;
    lcd_entry_t       fifo_din, fifo_dout;
    logic             fifo_full_w, fifo_empty;
    logic [FW-1:0]    fifo_count;

    assign fifo_din = {wr_rs, wr_data};

    lcd_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (wr_en),
        .pop    (fifo_pop),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full_w),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_en_d    = lcd_en_q;
        init_done_d = init_done_q;
        fifo_pop    = 1'b0;
        wait_last   = is_slow_cmd(lcd_rs_q, lcd_data_q) ? CLEAR_LAST : CMD_LAST;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LAST) state_d = ST_INIT;
            end
            ST_INIT: begin
                lcd_data_d = init_rom(init_idx_q);
                lcd_rs_d   = 1'b0;
                state_d    = ST_SETUP;
            end
            ST_SETUP: begin
                lcd_en_d = 1'b1;
                state_d  = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    lcd_en_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    if (!init_done_q) begin
                        if (init_idx_q == INIT_LAST) begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            init_idx_d = init_idx_q + 1'b1;
                            state_d    = ST_INIT;
                        end
                    // Chain straight into the next buffered byte without an idle cycle.
                    end else if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        lcd_data_d = fifo_dout.data;
                        lcd_rs_d   = fifo_dout.rs;
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    lcd_data_d = fifo_dout.data;
                    lcd_rs_d   = fifo_dout.rs;
                    state_d    = ST_SETUP;
                end
            end
            default: state_d = ST_PWRUP;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A write into a full buffer is lost unless the FSM frees a slot that same cycle.
        overflow_d = overflow_q | (wr_en && (fifo_count == FULL_CNT) && !fifo_pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            lcd_data_q  <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            init_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_en_q    <= lcd_en_d;
            init_done_q <= init_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign init_done = init_done_q;
    assign fifo_full = fifo_full_w;
    assign overflow  = overflow_q;

endmodule
